mem_read_responder: RTL
=======================

Name: mem_read_responder

Overview:
- Main-memory side of the cache fill protocol: the responder that serves the burst word requests issued by the cache fill FSMs.
- Single-ported word memory. Writes commit in one cycle. Reads are fully pipelined: one new read can be accepted every cycle, and each returns one-cycle `data_valid` a fixed `LATENCY` later.
- Drop-in for the unified main memory behind the instruction/data cache arbitration.

Parameters:
- `ADDR_W`, 16, byte address width.
- `DATA_W`, 16, word width.
- `DEPTH`, 1024, words stored; word index = `addr[ADDR_W-1:1]` mod `DEPTH`; `DEPTH` must be a power of two.
- `LATENCY`, 4, clock edges from request sample to the edge at which the consumer samples `data_valid`; must be >= 1.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `enable` input 1: request strobe, sampled every rising edge.
- `wr` input 1: with `enable`, 1 = write, 0 = read.
- `addr` input `ADDR_W`: byte address; bit 0 ignored.
- `data_in` input `DATA_W`: write data.
- `data_out` output `DATA_W`: read data, meaningful only while `data_valid` = 1.
- `data_valid` output 1: one-cycle response strobe per accepted read.
- `inflight` output 3: count of accepted reads not yet returned (saturating width 3; `LATENCY` <= 7).

Behaviour:
- Reset (asynchronous assert, synchronous-release use):
  - all pipeline valid bits cleared; `data_valid` = 0, `data_out` = 0, `inflight` = 0.
  - In-flight reads are discarded and never returned.
  - Array contents are NOT reset; simulation initialises the array to 0.
- Write (`enable`=1, `wr`=1 at edge n): `mem[idx]` <= `data_in` at edge n. No response and no `data_valid`. Does not enter the pipeline.
- Read (`enable`=1, `wr`=0 at edge n):
  - array read uses `mem[idx]` as it stands before edge n (a write in the same cycle is impossible: single request per cycle);
  - the word is captured into pipeline stage 0 with valid = 1.
- Pipeline:
  - `LATENCY` stages of {valid, data}; stage i shifts to i+1 every edge, unconditionally (no backpressure).
  - Last stage drives the outputs: `data_valid` = `stage[LATENCY-1].valid`; `data_out` = `stage[LATENCY-1].data` when valid, else 0.
  - Net effect: for a read sampled at edge n, `data_valid` = 1 between edges n+LATENCY-1 and n+LATENCY.
  - `LATENCY` = 1 means a registered array read.
- Ordering: responses return strictly in request order, one per accepted read. Back-to-back reads produce back-to-back `data_valid` pulses.
- Snapshot semantics: read data is fixed at acceptance. A write to the same word issued while the read is in flight does not alter the returned value. A read accepted at the edge after a write returns the new value.
- `inflight`:
  - +1 on an accepted read;
  - -1 when `data_valid` is high at an edge;
  - both in the same cycle: unchanged.
  - Equals the popcount of the stage valid bits.
- `enable` = 0: pipeline still advances; no new entry.
- `wr` is ignored when `enable` = 0.
- Address wrap: indices >= `DEPTH` alias modulo `DEPTH`.

Test Plan:
1. Reset mid-burst: issue reads at 3 consecutive edges, assert `rst` asynchronously between edges 2 and 3 -> `data_valid`, `data_out`, `inflight` go to 0 immediately; no `data_valid` pulse ever follows; a subsequent read returns normally.
2. Write then read: write 0xBEEF to 0x0010 at edge 0, read 0x0010 at edge 1 -> `data_valid` = 1 only between edges 4 and 5, with `data_out` = 0xBEEF; `inflight` = 1 from after edge 1 until edge 5.
3. 8-word fill burst: write 0x1000+k to addresses 0x0040+2k, then read all 8 on consecutive edges -> 8 consecutive `data_valid` pulses carrying 0x1000..0x1007 in order. `inflight` peaks at 4 and holds 4 during the middle of the burst, while reads are still being accepted and the first responses are returning.
4. Snapshot: write 0x1111 to 0x0020; read 0x0020 at edge n; write 0x2222 to 0x0020 at edge n+1 -> response = 0x1111. A read at edge n+2 returns 0x2222.
5. Alias and odd address: write 0xA5A5 to 0x0001; read 0x0800 (`DEPTH` = 1024 wrap to index 0) -> 0xA5A5.
6. Gaps: reads at edges 0, 2, 3 with `enable` = 0 at edge 1 -> `data_valid` pattern 1, 0, 1, 1 over edges 4-7; `data_out` = 0 when `data_valid` = 0.

Source files
------------

// File: rtl/mem_read_responder.sv
// Main-memory read/write responder for the cache fill protocol.
// Single-ported word array with a fixed-latency, non-stallable read pipeline.
module mem_read_responder #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [2:0]        inflight
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } stage_t;

  logic [DATA_W-1:0] mem [DEPTH];
  stage_t            stage_q [LATENCY];

  logic [IDX_W-1:0]  idx;
  logic              rd_accept;
  logic              wr_accept;
  logic              unused_addr;

  // Word index: drop the byte bit, keep the low IDX_W word-address bits so
  // addresses beyond the array alias modulo DEPTH.
  assign idx         = addr[IDX_W:1];
  assign unused_addr = ^addr;
  assign rd_accept   = enable & ~wr;
  assign wr_accept   = enable & wr;

  // NOTE: the array deliberately has no reset so it maps onto a RAM macro;
  // only the pipeline control state is reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[idx] <= data_in;
    end
  end

  // Stage 0 samples the array before any same-edge write, which fixes the
  // returned data at acceptance. Idle stages carry zero data so data_out
  // is already 0 whenever data_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
      inflight <= '0;
    end else begin
      stage_q[0].valid <= rd_accept;
      stage_q[0].data  <= rd_accept ? mem[idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      case ({rd_accept, data_valid})
        2'b10:   inflight <= inflight + 3'd1;
        2'b01:   inflight <= inflight - 3'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign data_valid = stage_q[LATENCY-1].valid;
  assign data_out   = stage_q[LATENCY-1].data;

endmodule
